// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit with HI/LO registers.
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // True for the multi-cycle operations that occupy the unit.
  function automatic logic mdu_is_md(input logic [2:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_divide.sv
// Combinational 32-bit signed/unsigned divider: truncating quotient,
// remainder carrying the dividend's sign, and a divide-by-zero flag.
module mdu_divide (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    // NOTE: every variable gets a value at the top of the block, so no
    // path can leave one unassigned and infer a latch.
    div_by_zero = (divisor == 32'd0);
    a_neg       = is_signed & dividend[31];
    b_neg       = is_signed & divisor[31];
    a_mag       = a_neg ? (~dividend + 32'd1) : dividend;
    b_mag       = b_neg ? (~divisor + 32'd1) : divisor;
    uq          = 32'd0;
    ur          = 32'd0;
    quotient    = 32'd0;
    remainder   = 32'd0;
    if (!div_by_zero) begin
      uq        = a_mag / b_mag;
      ur        = a_mag % b_mag;
      // 0x80000000 / -1 wraps back to 0x80000000 through the negate.
      quotient  = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
      remainder = a_neg ? (~ur + 32'd1) : ur;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers: results are computed at accept,
// parked in pending registers, and committed when the busy countdown expires.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_rs_Data,
  input  logic [31:0] in_rt_Data,
  input  logic [2:0]  in_MDU_Op,
  input  logic        in_MDU_Start,
  output logic [31:0] out_HI,
  output logic [31:0] out_LO,
  output logic        out_Busy,
  output logic        out_Stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic          is_mult;
  logic          op_signed;
  logic          accept;
  logic [63:0]   mul_a;
  logic [63:0]   mul_b;
  logic [63:0]   product;
  logic [31:0]   quotient;
  logic [31:0]   remainder;
  logic          div_by_zero;

  assign is_mult   = (in_MDU_Op == MDU_MULT) || (in_MDU_Op == MDU_MULTU);
  assign op_signed = (in_MDU_Op == MDU_MULT) || (in_MDU_Op == MDU_DIV);
  assign accept    = in_MDU_Start && !busy_q && mdu_is_md(in_MDU_Op);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  assign mul_a   = {{32{op_signed & in_rs_Data[31]}}, in_rs_Data};
  assign mul_b   = {{32{op_signed & in_rt_Data[31]}}, in_rt_Data};
  assign product = mul_a * mul_b;

  mdu_divide u_divide (
    .dividend    (in_rs_Data),
    .divisor     (in_rt_Data),
    .is_signed   (op_signed),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (accept) begin
      busy_d = 1'b1;
      if (is_mult) begin
        cnt_d     = CW'(MULT_CYCLES);
        pend_hi_d = product[63:32];
        pend_lo_d = product[31:0];
        pend_wr_d = 1'b1;
      end else begin
        cnt_d     = CW'(DIV_CYCLES);
        pend_hi_d = remainder;
        pend_lo_d = quotient;
        pend_wr_d = !div_by_zero;
      end
    end else if (in_MDU_Start && in_MDU_Op == MDU_MTHI) begin
      hi_d = in_rs_Data;
    end else if (in_MDU_Start && in_MDU_Op == MDU_MTLO) begin
      lo_d = in_rs_Data;
    end
  end

  // NOTE: non-blocking assignments make every flop sample the pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign out_HI    = hi_q;
  assign out_LO    = lo_q;
  assign out_Busy  = busy_q;
  assign out_Stall = busy_q | (in_MDU_Start & mdu_is_md(in_MDU_Op));

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios plus random operations
// compared against a plain-arithmetic HI/LO model.
module tb_mdu_hilo;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [2:0]  op;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_rs_Data   (rs),
    .in_rt_Data   (rt),
    .in_MDU_Op    (op),
    .in_MDU_Start (start),
    .out_HI       (hi),
    .out_LO       (lo),
    .out_Busy     (busy),
    .out_Stall    (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural result of a MULT/MULTU/DIV/DIVU on the model regs.
  task automatic ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd1: begin r = 64'(sa * sb); m_hi = r[63:32]; m_lo = r[31:0]; end
      3'd2: begin r = ua * ub;      m_hi = r[63:32]; m_lo = r[31:0]; end
      3'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string nm);
    int n;
    int cyc;
    n = (o == 3'd1 || o == 3'd2) ? MC : DC;
    rs = a; rt = b; op = o; start = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL %s stall_on_start: got %b want 1", nm, stall);
    end
    step();
    start = 1'b0; op = 3'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      total++;
      if (hi !== m_hi || lo !== m_lo || stall !== 1'b1) begin
        bad++;
        $display("FAIL %s during_busy: hi=%h lo=%h stall=%b want hi=%h lo=%h stall=1",
                 nm, hi, lo, stall, m_hi, m_lo);
      end
      step();
      cyc++;
    end
    total++;
    if (cyc != n) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", nm, cyc, n);
    end
    ref_md(o, a, b);
    total++;
    if (hi !== m_hi || lo !== m_lo) begin
      bad++;
      $display("FAIL %s result: hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] a, input string nm);
    rs = a; op = o; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0;
    if (o == 3'd5) m_hi = a;
    if (o == 3'd6) m_lo = a;
    total++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s mt: hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
               nm, hi, lo, busy, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    #12;
    total++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b stall=%b want all 0", hi, lo, busy, stall);
    end
    reset = 1'b0;
    step();
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_directed();
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      bad++;
      $display("FAIL mult_neg_const: hi=%h lo=%h want FFFFFFFF FFFFFFFA", hi, lo);
    end
    run_md(3'd2, 32'hFFFF_FFFF, 32'd2, "multu");
    total++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL multu_const: hi=%h lo=%h want 00000001 FFFFFFFE", hi, lo);
    end
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_neg_const: hi=%h lo=%h want FFFFFFFF FFFFFFFD", hi, lo);
    end
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, "divu");
    total++;
    if (hi !== 32'h0000_0001 || lo !== 32'h7FFF_FFFC) begin
      bad++;
      $display("FAIL divu_const: hi=%h lo=%h want 00000001 7FFFFFFC", hi, lo);
    end
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    total++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL div_ovf_const: hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_mt();
    int cyc;
    do_mt(3'd5, 32'h1234_5678, "mthi_idle");
    do_mt(3'd6, 32'h0BAD_F00D, "mtlo_idle");
    // MTLO presented while a DIV is running must be dropped.
    rs = 32'd100; rt = 32'd7; op = 3'd3; start = 1'b1;
    step();
    rs = 32'hDEAD_BEEF; op = 3'd6;
    step();
    start = 1'b0; op = 3'd0;
    total++;
    if (lo !== m_lo || busy !== 1'b1) begin
      bad++;
      $display("FAIL mtlo_busy: lo=%h busy=%b want lo=%h busy=1", lo, busy, m_lo);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin step(); cyc++; end
    total++;
    if (cyc != DC - 1) begin
      bad++;
      $display("FAIL mtlo_busy_cycles: got %0d want %0d", cyc, DC - 1);
    end
    ref_md(3'd3, 32'd100, 32'd7);
    total++;
    if (hi !== m_hi || lo !== m_lo) begin
      bad++;
      $display("FAIL mtlo_busy_result: hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_div_zero();
    do_mt(3'd5, 32'h0000_000A, "dz_set_hi");
    do_mt(3'd6, 32'h0000_000B, "dz_set_lo");
    run_md(3'd3, 32'd5, 32'd0, "div_zero");
    total++;
    if (hi !== 32'h0000_000A || lo !== 32'h0000_000B) begin
      bad++;
      $display("FAIL div_zero_const: hi=%h lo=%h want 0000000A 0000000B", hi, lo);
    end
    run_md(3'd4, 32'hFFFF_0000, 32'd0, "divu_zero");
  endtask

  task automatic test_async_reset();
    do_mt(3'd5, 32'h5555_AAAA, "ar_set_hi");
    do_mt(3'd6, 32'hAAAA_5555, "ar_set_lo");
    rs = 32'h0001_0000; rt = 32'h0001_0000; op = 3'd1; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
    end
    #1;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    for (int i = 0; i < MC + 2; i++) step();
    total++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_discard: hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    rs = 32'h0000_1234; rt = 32'hFFFF_FF00; op = 3'd1; start = 1'b1;
    step();
    // Controller holds a second MD instruction while stalled.
    rs = 32'd1000; rt = 32'd3; op = 3'd3;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      total++;
      if (stall !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        bad++;
        $display("FAIL b2b_busy: stall=%b hi=%h lo=%h want stall=1 hi=%h lo=%h",
                 stall, hi, lo, m_hi, m_lo);
      end
      step();
      cyc++;
    end
    start = 1'b0; op = 3'd0;
    total++;
    if (cyc != MC) begin
      bad++;
      $display("FAIL b2b_busy_cycles: got %0d want %0d", cyc, MC);
    end
    ref_md(3'd1, 32'h0000_1234, 32'hFFFF_FF00);
    step();
    total++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_result: hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
               hi, lo, busy, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      if (o >= 3'd1 && o <= 3'd4) begin
        run_md(o, a, b, "rand_md");
      end else if (o == 3'd5 || o == 3'd6) begin
        do_mt(o, a, "rand_mt");
      end else begin
        rs = a; rt = b; op = o; start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
          bad++;
          $display("FAIL rand_nop_stall: got %b want 0", stall);
        end
        step();
        start = 1'b0; op = 3'd0;
        total++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
          bad++;
          $display("FAIL rand_nop: hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
                   hi, lo, busy, m_hi, m_lo);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt();
    test_div_zero();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
